// File: rtl/mem_stage_if.sv
// Data-memory bus between mem_stage (master) and the memory (slave).
// Ports: req/we/addr/be/wdata from master; rdata/ack back from slave.
interface mem_stage_if;
    logic        dmem_req_o;
    logic        dmem_we_o;
    logic [31:0] dmem_addr_o;
    logic [3:0]  dmem_be_o;
    logic [31:0] dmem_wdata_o;
    logic [31:0] dmem_rdata_i;
    logic        dmem_ack_i;

    modport master (
        output dmem_req_o,
        output dmem_we_o,
        output dmem_addr_o,
        output dmem_be_o,
        output dmem_wdata_o,
        input  dmem_rdata_i,
        input  dmem_ack_i
    );

    modport slave (
        input  dmem_req_o,
        input  dmem_we_o,
        input  dmem_addr_o,
        input  dmem_be_o,
        input  dmem_wdata_o,
        output dmem_rdata_i,
        output dmem_ack_i
    );
endinterface

// File: rtl/mem_stage.sv
// RISC-V MEM pipeline stage: load/store bus access and MEM/WB register.
// Ports: clk, rst (async, active-high), ex_mem_i, mem_wb_o, stall_o,
//   misalign_o, dmem (mem_stage_if.master).
// Optional: MEM_MISALIGN_TRAP_EN turns misaligned accesses into traps.
package mem_pkg;
    typedef struct packed {
        logic       reg_write;
        logic [1:0] wb_sel;
        logic       mem_read;
        logic       mem_write;
        logic [2:0] mem_size;
    } ctrl_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] alu_res;
        logic [31:0] rs2_data;
        logic [4:0]  rd;
        ctrl_t       ctrl;
    } EX_MEM_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] alu_res;
        logic [31:0] mem_data;
        logic [4:0]  rd;
        ctrl_t       ctrl;
    } MEM_WB_t;
endpackage

module mem_stage
    import mem_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  EX_MEM_t     ex_mem_i,
    output MEM_WB_t     mem_wb_o,
    output logic        stall_o,
    output logic        misalign_o,
    mem_stage_if.master dmem
);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t      state_q;
    state_t      state_d;
    logic        mem_op;
    logic        misaligned;
    logic        access;
    logic        trap;
    logic        is_half;
    logic        is_word;
    logic [1:0]  eff_off;
    logic [31:0] lane;
    logic [31:0] load_data;
    MEM_WB_t     wb_d;

    // Address decode; eff_off drops the low bits a half/word ignores.
    always_comb begin
        mem_op     = ex_mem_i.valid &
                     (ex_mem_i.ctrl.mem_read | ex_mem_i.ctrl.mem_write);
        is_half    = ex_mem_i.ctrl.mem_size[1:0] == 2'b01;
        is_word    = ex_mem_i.ctrl.mem_size[1];
        misaligned = (is_half & ex_mem_i.alu_res[0]) |
                     (is_word & (ex_mem_i.alu_res[1:0] != 2'b00));
        if (is_word)
            eff_off = 2'b00;
        else if (is_half)
            eff_off = {ex_mem_i.alu_res[1], 1'b0};
        else
            eff_off = ex_mem_i.alu_res[1:0];
    end

`ifdef MEM_MISALIGN_TRAP_EN
    assign trap   = (state_q == IDLE) & mem_op & misaligned;
    assign access = mem_op & ~misaligned;
`else
    assign trap   = 1'b0;
    assign access = mem_op;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // Ack is only meaningful in WAIT; in IDLE a stray ack is ignored.
    always_comb begin
        state_d         = state_q;
        stall_o         = 1'b0;
        dmem.dmem_req_o = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (access) begin
                    state_d = WAIT;
                    stall_o = ~rst;
                end
            end
            WAIT: begin
                dmem.dmem_req_o = 1'b1;
                stall_o         = ~dmem.dmem_ack_i & ~rst;
                if (dmem.dmem_ack_i)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Bus fields follow ex_mem_i, which upstream holds while stalled.
    always_comb begin
        dmem.dmem_addr_o  = {ex_mem_i.alu_res[31:2], 2'b00};
        dmem.dmem_we_o    = ex_mem_i.ctrl.mem_write;
        dmem.dmem_be_o    = 4'b1111;
        dmem.dmem_wdata_o = ex_mem_i.rs2_data;
        if (ex_mem_i.ctrl.mem_write) begin
            unique case (ex_mem_i.ctrl.mem_size[1:0])
                2'b00: begin
                    dmem.dmem_be_o    = 4'b0001 << eff_off;
                    dmem.dmem_wdata_o = {4{ex_mem_i.rs2_data[7:0]}};
                end
                2'b01: begin
                    dmem.dmem_be_o    = 4'b0011 << eff_off;
                    dmem.dmem_wdata_o = {2{ex_mem_i.rs2_data[15:0]}};
                end
                default: begin
                    dmem.dmem_be_o    = 4'b1111;
                    dmem.dmem_wdata_o = ex_mem_i.rs2_data;
                end
            endcase
        end
    end

    // Load lane select and sign/zero extension.
    always_comb begin
        lane      = dmem.dmem_rdata_i >> {eff_off, 3'b000};
        load_data = dmem.dmem_rdata_i;
        unique case (ex_mem_i.ctrl.mem_size)
            3'b000:  load_data = {{24{lane[7]}}, lane[7:0]};
            3'b100:  load_data = {24'h0, lane[7:0]};
            3'b001:  load_data = {{16{lane[15]}}, lane[15:0]};
            3'b101:  load_data = {16'h0, lane[15:0]};
            default: load_data = dmem.dmem_rdata_i;
        endcase
    end

    // Unstalled edges in WAIT are ack edges; all others are pass-through.
    always_comb begin
        wb_d          = '0;
        wb_d.valid    = ex_mem_i.valid;
        wb_d.pc       = ex_mem_i.pc;
        wb_d.alu_res  = ex_mem_i.alu_res;
        wb_d.rd       = ex_mem_i.rd;
        wb_d.ctrl     = ex_mem_i.ctrl;
        wb_d.mem_data = 32'h0;
        if (state_q == WAIT && !ex_mem_i.ctrl.mem_write)
            wb_d.mem_data = load_data;
        if (trap)
            wb_d.ctrl.reg_write = 1'b0;
        if (stall_o)
            wb_d = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_wb_o   <= '0;
            misalign_o <= 1'b0;
        end else begin
            mem_wb_o   <= wb_d;
            misalign_o <= trap & ~stall_o;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage with a scoreboard of MEM/WB results.
// Ports: drives ex_mem_i and the slave side of mem_stage_if.
module tb_mem_stage;
    import mem_pkg::*;

    logic      clk = 1'b0;
    logic      rst;
    EX_MEM_t   ex_mem_i;
    MEM_WB_t   mem_wb_o;
    logic      stall_o;
    logic      misalign_o;
    int        n_tests = 0;
    int        n_fail = 0;
    MEM_WB_t   exp_q[$];

    mem_stage_if dmem();

    mem_stage dut (
        .clk       (clk),
        .rst       (rst),
        .ex_mem_i  (ex_mem_i),
        .mem_wb_o  (mem_wb_o),
        .stall_o   (stall_o),
        .misalign_o(misalign_o),
        .dmem      (dmem)
    );

    always #5 clk = ~clk;

    function automatic EX_MEM_t mk(input logic v, input logic [31:0] pc,
                                   input logic [31:0] alu,
                                   input logic [31:0] rs2,
                                   input logic [4:0] rd, input logic rw,
                                   input logic rdop, input logic wrop,
                                   input logic [2:0] sz);
        EX_MEM_t e;
        e = '0;
        e.valid = v;
        e.pc = pc;
        e.alu_res = alu;
        e.rs2_data = rs2;
        e.rd = rd;
        e.ctrl.reg_write = rw;
        e.ctrl.wb_sel = rdop ? 2'b01 : 2'b00;
        e.ctrl.mem_read = rdop;
        e.ctrl.mem_write = wrop;
        e.ctrl.mem_size = sz;
        return e;
    endfunction

    function automatic MEM_WB_t wb_of(input EX_MEM_t e,
                                      input logic [31:0] md);
        MEM_WB_t w;
        w.valid = e.valid;
        w.pc = e.pc;
        w.alu_res = e.alu_res;
        w.mem_data = md;
        w.rd = e.rd;
        w.ctrl = e.ctrl;
        return w;
    endfunction

    // Drives one instruction and a memory responder until writeback.
    task automatic run_access(input EX_MEM_t e, input int waits,
                              input logic [31:0] rdata,
                              output int stalls, output int n_req,
                              output logic [31:0] addr,
                              output logic [3:0] be,
                              output logic [31:0] wdata,
                              output logic we, output int lat);
        int w;
        bit done;
        w = 0;
        done = 0;
        stalls = 0;
        n_req = 0;
        lat = 0;
        addr = '0;
        be = '0;
        wdata = '0;
        we = 1'b0;
        ex_mem_i = e;
        dmem.dmem_ack_i = 1'b0;
        for (int cyc = 1; cyc <= 20 && !done; cyc++) begin
            if (dmem.dmem_req_o) begin
                n_req++;
                addr = dmem.dmem_addr_o;
                be = dmem.dmem_be_o;
                wdata = dmem.dmem_wdata_o;
                we = dmem.dmem_we_o;
                if (w == waits) begin
                    dmem.dmem_ack_i = 1'b1;
                    dmem.dmem_rdata_i = rdata;
                end else begin
                    w++;
                end
            end
            @(negedge clk);
            if (stall_o)
                stalls++;
            @(posedge clk);
            #1;
            dmem.dmem_ack_i = 1'b0;
            if (mem_wb_o.valid) begin
                lat = cyc;
                done = 1;
                ex_mem_i = '0;
            end
        end
        if (!done)
            ex_mem_i = '0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        dmem.dmem_ack_i = 1'b0;
        dmem.dmem_rdata_i = '0;
        ex_mem_i = mk(1, 32'h10, 32'h1000, 0, 5'd1, 1, 1, 0, 3'b010);
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_tests++;
        if (stall_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_stall: got %b want 0", stall_o);
        end
        n_tests++;
        if (dmem.dmem_req_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_req: got %b want 0", dmem.dmem_req_o);
        end
        n_tests++;
        if (mem_wb_o !== '0) begin
            n_fail++;
            $display("FAIL reset_wb: got %h want 0", mem_wb_o);
        end
        n_tests++;
        if (misalign_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_misalign: got %b want 0", misalign_o);
        end
        @(posedge clk);
        #1;
        ex_mem_i = '0;
        rst = 1'b0;
    endtask

    task automatic test_alu;
        EX_MEM_t e;
        MEM_WB_t x;
        int st, nr, lat;
        logic [31:0] a, wd;
        logic [3:0] be;
        logic we;
        e = mk(1, 32'h100, 32'h55, 32'h0, 5'd3, 1, 0, 0, 3'b000);
        exp_q.push_back(wb_of(e, 32'h0));
        run_access(e, 0, 32'h0, st, nr, a, be, wd, we, lat);
        x = exp_q.pop_front();
        n_tests++;
        if (lat != 1 || mem_wb_o !== x) begin
            n_fail++;
            $display("FAIL alu_wb: got %h lat %0d want %h lat 1",
                     mem_wb_o, lat, x);
        end
        n_tests++;
        if (st != 0 || nr != 0) begin
            n_fail++;
            $display("FAIL alu_stall: got stalls %0d req %0d want 0 0",
                     st, nr);
        end
    endtask

    task automatic test_lb;
        EX_MEM_t e;
        MEM_WB_t x;
        int st, nr, lat;
        logic [31:0] a, wd;
        logic [3:0] be;
        logic we;
        e = mk(1, 32'h104, 32'h1003, 32'h0, 5'd4, 1, 1, 0, 3'b000);
        exp_q.push_back(wb_of(e, 32'hFFFF_FF80));
        run_access(e, 2, 32'h80FF_FF00, st, nr, a, be, wd, we, lat);
        x = exp_q.pop_front();
        n_tests++;
        if (lat != 4 || mem_wb_o !== x) begin
            n_fail++;
            $display("FAIL lb_wb: got %h lat %0d want %h lat 4",
                     mem_wb_o, lat, x);
        end
        n_tests++;
        if (a !== 32'h1000 || be !== 4'b1111 || we !== 1'b0) begin
            n_fail++;
            $display("FAIL lb_bus: got addr %h be %b we %b want 1000 1111 0",
                     a, be, we);
        end
        n_tests++;
        if (st != 3 || nr != 3) begin
            n_fail++;
            $display("FAIL lb_stall: got stalls %0d req %0d want 3 3",
                     st, nr);
        end
    endtask

    task automatic test_store;
        EX_MEM_t e;
        MEM_WB_t x;
        int st, nr, lat;
        logic [31:0] a, wd;
        logic [3:0] be;
        logic we;
        e = mk(1, 32'h108, 32'h2002, 32'h1234_ABCD, 5'd7, 1, 0, 1, 3'b001);
        exp_q.push_back(wb_of(e, 32'h0));
        run_access(e, 1, 32'hDEAD_BEEF, st, nr, a, be, wd, we, lat);
        x = exp_q.pop_front();
        n_tests++;
        if (mem_wb_o !== x || lat != 3) begin
            n_fail++;
            $display("FAIL sh_wb: got %h lat %0d want %h lat 3",
                     mem_wb_o, lat, x);
        end
        n_tests++;
        if (a !== 32'h2000 || be !== 4'b1100 || wd !== 32'hABCD_ABCD ||
            we !== 1'b1) begin
            n_fail++;
            $display("FAIL sh_bus: got %h %b %h %b want 2000 1100 abcdabcd 1",
                     a, be, wd, we);
        end
        e = mk(1, 32'h10C, 32'h6001, 32'h0000_00AB, 5'd0, 0, 0, 1, 3'b000);
        exp_q.push_back(wb_of(e, 32'h0));
        run_access(e, 0, 32'h0, st, nr, a, be, wd, we, lat);
        x = exp_q.pop_front();
        n_tests++;
        if (mem_wb_o !== x || be !== 4'b0010 || wd !== 32'hABAB_ABAB) begin
            n_fail++;
            $display("FAIL sb: got wb %h be %b wd %h want %h 0010 abababab",
                     mem_wb_o, be, wd, x);
        end
        e = mk(1, 32'h110, 32'h6008, 32'h8765_4321, 5'd0, 0, 0, 1, 3'b010);
        exp_q.push_back(wb_of(e, 32'h0));
        run_access(e, 0, 32'h0, st, nr, a, be, wd, we, lat);
        x = exp_q.pop_front();
        n_tests++;
        if (mem_wb_o !== x || be !== 4'b1111 || wd !== 32'h8765_4321 ||
            a !== 32'h6008) begin
            n_fail++;
            $display("FAIL sw: got wb %h a %h be %b wd %h want %h", mem_wb_o,
                     a, be, wd, x);
        end
    endtask

    task automatic test_lhu;
        EX_MEM_t e;
        MEM_WB_t x;
        int st, nr, lat;
        logic [31:0] a, wd;
        logic [3:0] be;
        logic we;
        e = mk(1, 32'h114, 32'h3002, 32'h0, 5'd9, 1, 1, 0, 3'b101);
        exp_q.push_back(wb_of(e, 32'h0000_F00D));
        run_access(e, 0, 32'hF00D_0000, st, nr, a, be, wd, we, lat);
        x = exp_q.pop_front();
        n_tests++;
        if (mem_wb_o !== x || lat != 2 || st != 1) begin
            n_fail++;
            $display("FAIL lhu: got %h lat %0d st %0d want %h lat 2 st 1",
                     mem_wb_o, lat, st, x);
        end
    endtask

    task automatic test_loads;
        logic [2:0]  sz[7];
        logic [31:0] ad[7];
        logic [31:0] md[7];
        EX_MEM_t e;
        MEM_WB_t x;
        int st, nr, lat;
        logic [31:0] a, wd;
        logic [3:0] be;
        logic we;
        sz = '{3'b000, 3'b000, 3'b000, 3'b100, 3'b001, 3'b101, 3'b001};
        ad = '{32'h100, 32'h101, 32'h102, 32'h103, 32'h102, 32'h100,
               32'h100};
        md = '{32'h0000_0022, 32'h0000_007F, 32'hFFFF_FFF1, 32'h0000_0080,
               32'hFFFF_80F1, 32'h0000_7F22, 32'h0000_7F22};
        for (int i = 0; i < 7; i++) begin
            e = mk(1, 32'h200 + i, ad[i], 0, 5'(i + 10), 1, 1, 0, sz[i]);
            exp_q.push_back(wb_of(e, md[i]));
            run_access(e, i % 3, 32'h80F1_7F22, st, nr, a, be, wd, we, lat);
            x = exp_q.pop_front();
            n_tests++;
            if (mem_wb_o !== x || a !== 32'h100) begin
                n_fail++;
                $display("FAIL load_%0d: got %h addr %h want %h addr 100",
                         i, mem_wb_o, a, x);
            end
        end
    endtask

    task automatic test_back_to_back;
        EX_MEM_t e[3];
        logic [31:0] md[3];
        int lt[3];
        MEM_WB_t x;
        int st, nr, lat;
        logic [31:0] a, wd;
        logic [3:0] be;
        logic we;
        e[0] = mk(1, 32'h300, 32'h11, 0, 5'd1, 1, 0, 0, 3'b000);
        e[1] = mk(1, 32'h304, 32'h7000, 0, 5'd2, 1, 1, 0, 3'b010);
        e[2] = mk(1, 32'h308, 32'h22, 0, 5'd3, 1, 0, 0, 3'b000);
        md = '{32'h0, 32'h1357_9BDF, 32'h0};
        lt = '{1, 2, 1};
        for (int i = 0; i < 3; i++)
            exp_q.push_back(wb_of(e[i], md[i]));
        for (int i = 0; i < 3; i++) begin
            run_access(e[i], 0, 32'h1357_9BDF, st, nr, a, be, wd, we, lat);
            x = exp_q.pop_front();
            n_tests++;
            if (mem_wb_o !== x || lat != lt[i]) begin
                n_fail++;
                $display("FAIL b2b_%0d: got %h lat %0d want %h lat %0d",
                         i, mem_wb_o, lat, x, lt[i]);
            end
        end
    endtask

    task automatic test_invalid;
        ex_mem_i = mk(0, 32'h400, 32'h8000, 0, 5'd5, 1, 1, 0, 3'b010);
        @(negedge clk);
        n_tests++;
        if (stall_o !== 1'b0 || dmem.dmem_req_o !== 1'b0) begin
            n_fail++;
            $display("FAIL invalid_slot: got stall %b req %b want 0 0",
                     stall_o, dmem.dmem_req_o);
        end
        @(posedge clk);
        #1;
        n_tests++;
        if (mem_wb_o.valid !== 1'b0 || mem_wb_o.pc !== 32'h400) begin
            n_fail++;
            $display("FAIL invalid_wb: got v %b pc %h want 0 400",
                     mem_wb_o.valid, mem_wb_o.pc);
        end
        ex_mem_i = '0;
    endtask

    task automatic test_rst_wait;
        int bad;
        ex_mem_i = mk(1, 32'h500, 32'h5000, 0, 5'd6, 1, 1, 0, 3'b010);
        @(posedge clk);
        #1;
        n_tests++;
        if (dmem.dmem_req_o !== 1'b1) begin
            n_fail++;
            $display("FAIL rstw_req_before: got %b want 1", dmem.dmem_req_o);
        end
        rst = 1'b1;
        #1;
        n_tests++;
        if (dmem.dmem_req_o !== 1'b0 || stall_o !== 1'b0) begin
            n_fail++;
            $display("FAIL rstw_drop: got req %b stall %b want 0 0",
                     dmem.dmem_req_o, stall_o);
        end
        ex_mem_i = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        dmem.dmem_ack_i = 1'b1;
        dmem.dmem_rdata_i = 32'hBAD0_BAD0;
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (dmem.dmem_req_o !== 1'b0)
                bad++;
            @(posedge clk);
            #1;
            dmem.dmem_ack_i = 1'b0;
            if (mem_wb_o.valid !== 1'b0)
                bad++;
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL rstw_stray_ack: got %0d bad cycles want 0", bad);
        end
    endtask

    task automatic test_misalign;
        EX_MEM_t e;
        MEM_WB_t x;
        int st, nr, lat;
        logic [31:0] a, wd;
        logic [3:0] be;
        logic we;
        e = mk(1, 32'h600, 32'h4001, 0, 5'd8, 1, 1, 0, 3'b010);
`ifdef MEM_MISALIGN_TRAP_EN
        x = wb_of(e, 32'h0);
        x.ctrl.reg_write = 1'b0;
        exp_q.push_back(x);
        run_access(e, 0, 32'hCAFE_BABE, st, nr, a, be, wd, we, lat);
        x = exp_q.pop_front();
        n_tests++;
        if (mem_wb_o !== x || misalign_o !== 1'b1 || lat != 1) begin
            n_fail++;
            $display("FAIL mis_trap: got %h mis %b lat %0d want %h 1 1",
                     mem_wb_o, misalign_o, lat, x);
        end
        n_tests++;
        if (nr != 0 || st != 0) begin
            n_fail++;
            $display("FAIL mis_nobus: got req %0d stall %0d want 0 0",
                     nr, st);
        end
        @(posedge clk);
        #1;
        n_tests++;
        if (misalign_o !== 1'b0) begin
            n_fail++;
            $display("FAIL mis_pulse: got %b want 0", misalign_o);
        end
`else
        exp_q.push_back(wb_of(e, 32'hCAFE_BABE));
        run_access(e, 1, 32'hCAFE_BABE, st, nr, a, be, wd, we, lat);
        x = exp_q.pop_front();
        n_tests++;
        if (mem_wb_o !== x || misalign_o !== 1'b0 || lat != 3) begin
            n_fail++;
            $display("FAIL mis_load: got %h mis %b lat %0d want %h 0 3",
                     mem_wb_o, misalign_o, lat, x);
        end
        n_tests++;
        if (a !== 32'h4000 || nr != 2) begin
            n_fail++;
            $display("FAIL mis_addr: got %h req %0d want 4000 2", a, nr);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_alu();
        test_lb();
        test_store();
        test_lhu();
        test_loads();
        test_back_to_back();
        test_invalid();
        test_rst_wait();
        test_misalign();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have clk, input, 1: sole clock; all state on rising edge.
REQ-002 SHALL have rst, input, 1: asynchronous, active-high reset.
REQ-003 SHALL have ex_mem_i, input, EX_MEM_t, with the following fields:
- valid, pc, alu_res (address or result), rs2_data (store data), rd.
- ctrl: reg_write, wb_sel, mem_read, mem_write, mem_size (funct3).
REQ-004 SHALL have mem_wb_o, output, MEM_WB_t, registered: valid, pc, alu_res, mem_data, rd, ctrl.
REQ-005 SHALL have stall_o, output, 1: upstream holds ex_mem_i stable while high.
REQ-006 SHALL have dmem_req_o, output, 1: bus request.
REQ-007 SHALL have dmem_we_o, output, 1: 1 = store.
REQ-008 SHALL have dmem_addr_o, output, 32: word-aligned address, i.e. alu_res with bits [1:0] = 0.
REQ-009 SHALL have dmem_be_o, output, 4: byte enables.
REQ-010 SHALL have dmem_wdata_o, output, 32: lane-replicated store data.
REQ-011 SHALL have dmem_rdata_i, input, 32: read word, valid in the ack cycle.
REQ-012 SHALL have dmem_ack_i, input, 1: access complete, one-cycle pulse.
REQ-013 SHALL have misalign_o, output, 1: registered misaligned-access flag.

Function
REQ-014 SHALL implement a two-state FSM:
- IDLE -> WAIT when ex_mem_i.valid and (mem_read or mem_write).
- WAIT -> IDLE on dmem_ack_i.
REQ-015 SHALL drive dmem_req_o = (state == WAIT), holding addr/we/be/wdata stable until the ack cycle inclusive.
REQ-016 SHALL drive stall_o combinationally = (IDLE and memory op valid) or (WAIT and not dmem_ack_i).
REQ-017 SHALL register non-memory ops, and invalid slots, into mem_wb_o the next edge (1-cycle latency), with mem_data = 0.
REQ-018 SHALL write mem_wb_o on the ack edge for memory ops (minimum latency 2 cycles), and hold mem_wb_o.valid = 0 (bubble) on every stalled edge.
REQ-019 SHALL select the load byte/half by alu_res[1:0]:
- LB/LH sign-extend to 32 bits.
- LBU/LHU zero-extend to 32 bits.
- LW passes the word unchanged.
REQ-020 SHALL generate stores as follows:
- SB: be = 0001 << addr[1:0], wdata = byte replicated x4.
- SH: be = 0011 << addr[1:0], wdata = half replicated x2.
- SW: be = 1111, wdata = rs2_data.
- Loads: be = 1111.
REQ-021 SHALL set mem_wb_o.mem_data = 0 for stores, and pass ctrl/pc/rd/alu_res unchanged.
REQ-022 SHALL ignore dmem_ack_i while in IDLE.
REQ-023 SHALL complete an access in the same cycle it is requested when ack arrives in the first WAIT cycle (zero wait states).

Reset
REQ-024 SHALL, while rst is high, force:
- state = IDLE, mem_wb_o all-zero (valid = 0), misalign_o = 0.
- dmem_req_o = 0, stall_o = 0.
REQ-025 SHALL abandon an in-flight access if rst asserts in WAIT: request drops immediately, no writeback is produced, and a later stray ack is ignored.

Configuration
REQ-026 SHALL, with MEM_MISALIGN_TRAP_EN defined, handle a misaligned access (half with addr[0] = 1, word with addr[1:0] != 0) as follows:
- No bus request is issued; the access is not stalled.
- mem_wb_o.valid = 1 and ctrl.reg_write forced to 0 the next edge.
- misalign_o = 1 for that one cycle.
REQ-027 SHALL, without MEM_MISALIGN_TRAP_EN, ignore the offending low address bits (half: addr[0]; word: addr[1:0]), proceed with the access normally, and tie misalign_o to 0.

Verification
REQ-028 SHALL cover: ADD result 0x55 to rd = 3, no memory op -> next cycle mem_wb_o.valid = 1, alu_res = 0x55, stall_o never high.
REQ-029 SHALL cover: LB at 0x1003, rdata = 0x80FF_FF00, ack after 2 wait cycles:
- dmem_addr_o = 0x1000.
- stall_o high 3 cycles.
- mem_data = 0xFFFF_FF80.
REQ-030 SHALL cover: SH at 0x2002 with rs2 = 0x1234_ABCD -> be = 1100, wdata = 0xABCD_ABCD, we = 1, mem_wb_o.reg_write unchanged.
REQ-031 SHALL cover: LHU at 0x3002, rdata = 0xF00D_0000, zero-wait ack -> mem_data = 0x0000_F00D, 2-cycle latency.
REQ-032 SHALL cover: rst asserted in WAIT, then ack pulsed after release -> no valid writeback, dmem_req_o = 0 immediately.
REQ-033 SHALL cover: LW at 0x4001 -> with macro defined, misalign_o = 1, no request, reg_write = 0; without the macro, request to 0x4000 and normal load.
